// File: rtl/freq_mult_pkg.sv
// Shared types and helpers for the parametrised shift-add frequency multiplier.
package freq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Saturation works on a fixed-width carrier, so VW+UW must stay below this.
    localparam int MAX_W = 64;

    function automatic int cnt_width(input int uw);
        return $clog2(uw > 1 ? uw : 2);
    endfunction

    function automatic logic [MAX_W-1:0] saturate(input logic [MAX_W-1:0] value,
                                                  input int vw);
        logic [MAX_W-1:0] limit;
        limit = (vw >= MAX_W) ? '1 : ((MAX_W'(1) << vw) - MAX_W'(1));
        return (value > limit) ? limit : value;
    endfunction

endpackage

// File: rtl/freq_mult_param.sv
// Sequential radix-2 shift-add multiplier: prod = vi * ui, one RUN cycle per multiplier bit.
// Handshake: start is sampled only in IDLE; done pulses once and the results stay valid until the next done.
module freq_mult_param
    import freq_mult_pkg::*;
#(
    parameter int VW         = 16,
    parameter int UW         = 2,
    parameter int EARLY_EXIT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [VW-1:0]    vi,
    input  logic [UW-1:0]    ui,
    output logic             busy,
    output logic             done,
    output logic [VW+UW-1:0] prod,
    output logic [VW-1:0]    sat_prod,
    output logic             ovf,
    output state_t           dbg_state
);

    localparam int PW = VW + UW;
    localparam int CW = cnt_width(UW);

    state_t           state;
    state_t           state_next;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    mcand;
    logic [UW-1:0]    mq;
    logic [CW-1:0]    cnt;

    logic [PW-1:0]    acc_sum;
    logic [UW-1:0]    mq_shift;
    logic             last_bit;
    logic [MAX_W-1:0] sat_wide;
    logic [VW-1:0]    sat_next;
    logic             ovf_next;

    always_comb begin
        state_next = state;
        acc_sum    = mq[0] ? (acc + mcand) : acc;
        mq_shift   = mq >> 1;
        last_bit   = (cnt == CW'(UW - 1)) || ((EARLY_EXIT != 0) && (mq_shift == '0));
        sat_wide   = saturate(MAX_W'(acc_sum), VW);
        sat_next   = sat_wide[VW-1:0];
        // Clamping changed the value exactly when the product spilled past VW bits.
        ovf_next   = (sat_wide != MAX_W'(acc_sum));

        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            acc      <= '0;
            mcand    <= '0;
            mq       <= '0;
            cnt      <= '0;
            prod     <= '0;
            sat_prod <= '0;
            ovf      <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand <= PW'(vi);
                        mq    <= ui;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    acc   <= acc_sum;
                    mcand <= mcand << 1;
                    mq    <= mq_shift;
                    cnt   <= cnt + CW'(1);
                    if (last_bit) begin
                        prod     <= acc_sum;
                        sat_prod <= sat_next;
                        ovf      <= ovf_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign dbg_state = state;

endmodule
